// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
//   Shared types for the ROM access arbiter:
//     state_t  - controller FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//     req_id_t - requester identifier (0 = fetch, 1 = data)
//     REQ0/REQ1 - requester id constants
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rom_access_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter, purely combinational.
//   Ports:
//     req   in  [1:0]    request vector (bit n = requester n)
//     last  in  req_id_t requester granted most recently
//     grant out req_id_t winning requester (meaningful only when any=1)
//     any   out          at least one request present
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = REQ0;
    if (req[0] && req[1]) begin
      // Contention: favour whoever did not win last time.
      grant = (last == REQ0) ? REQ1 : REQ0;
    end else if (req[1]) begin
      grant = REQ1;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
//   Shares one asynchronous ROM between two synchronous requesters
//   (0 = fetch, 1 = data). Round-robin arbitration, registered ROM
//   address/enables, fixed wait of WAIT_CYCLES cycles to cover tACC, then
//   the ROM data is captured into rdata and the winner gets a one-cycle ack.
//   Optional feature macro: ROM_ARB_LAST_ADDR_CACHE_EN
//     defined   - 1-entry (addr, data, valid) cache; a hit skips the ROM
//                 access and acks one cycle after the request is sampled.
//     undefined - every request performs a full ROM access.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req0/addr0/ack0     requester 0 handshake
//     req1/addr1/ack1     requester 1 handshake
//     rdata               captured ROM data, held until next capture
//     busy                controller not in IDLE
//     rom_A/rom__CS/rom__OE  registered ROM pins (enables active low)
//     rom_D               ROM data pins
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [AWIDTH-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [AWIDTH-1:0] addr1,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdata,
  output logic              busy,
  output logic [AWIDTH-1:0] rom_A,
  output logic              rom__CS,
  output logic              rom__OE,
  input  logic [DWIDTH-1:0] rom_D
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  req_id_t           grant_reg, grant_next;
  req_id_t           last_reg, last_next;
  logic [AWIDTH-1:0] addr_reg, addr_next;
  // One register drives both _CS and _OE so they can never diverge.
  logic              en_n_reg, en_n_next;
  logic [DWIDTH-1:0] rdata_reg, rdata_next;
  logic              ack0_reg, ack0_next;
  logic              ack1_reg, ack1_next;

  req_id_t           arb_grant;
  logic              arb_any;
  logic [AWIDTH-1:0] win_addr;
  logic              cache_hit;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .last  (last_reg),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign win_addr = (arb_grant == REQ1) ? addr1 : addr0;

`ifdef ROM_ARB_LAST_ADDR_CACHE_EN
  logic [AWIDTH-1:0] cache_addr_reg, cache_addr_next;
  logic [DWIDTH-1:0] cache_data_reg, cache_data_next;
  logic              cache_valid_reg, cache_valid_next;

  assign cache_hit = cache_valid_reg && (win_addr == cache_addr_reg);

  always_comb begin
    cache_addr_next  = cache_addr_reg;
    cache_data_next  = cache_data_reg;
    cache_valid_next = cache_valid_reg;
    // Refill on every real ROM capture.
    if (state_reg == ACCESS && cnt_reg == '0) begin
      cache_addr_next  = addr_reg;
      cache_data_next  = rom_D;
      cache_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_addr_reg  <= '0;
      cache_data_reg  <= '0;
      cache_valid_reg <= 1'b0;
    end else begin
      cache_addr_reg  <= cache_addr_next;
      cache_data_reg  <= cache_data_next;
      cache_valid_reg <= cache_valid_next;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    en_n_next  = en_n_reg;
    rdata_next = rdata_reg;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          grant_next = arb_grant;
          if (cache_hit) begin
`ifdef ROM_ARB_LAST_ADDR_CACHE_EN
            rdata_next = cache_data_reg;
`endif
            ack0_next  = (arb_grant == REQ0);
            ack1_next  = (arb_grant == REQ1);
            state_next = DONE;
          end else begin
            addr_next  = win_addr;
            en_n_next  = 1'b0;
            cnt_next   = CNT_LOAD;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Address and enables are held from the latched copy; requester
        // inputs are ignored here.
        if (cnt_reg == '0) begin
          rdata_next = rom_D;
          ack0_next  = (grant_reg == REQ0);
          ack1_next  = (grant_reg == REQ1);
          en_n_next  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DONE: begin
        last_next  = grant_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      grant_reg <= REQ0;
      last_reg  <= REQ1;
      addr_reg  <= '0;
      en_n_reg  <= 1'b1;
      rdata_reg <= '0;
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      en_n_reg  <= en_n_next;
      rdata_reg <= rdata_next;
      ack0_reg  <= ack0_next;
      ack1_reg  <= ack1_next;
    end
  end

  assign ack0    = ack0_reg;
  assign ack1    = ack1_reg;
  assign rdata   = rdata_reg;
  assign busy    = (state_reg != IDLE);
  assign rom_A   = addr_reg;
  assign rom__CS = en_n_reg;
  assign rom__OE = en_n_reg;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter
//   Scoreboard bench for rom_access_arbiter (AWIDTH=4, DWIDTH=8,
//   WAIT_CYCLES=2). ROM image: word n = n. Stimulus pushes the expected
//   (requester, data, ack cycle) per request; a negedge monitor pops and
//   compares on every ack. Honours ROM_ARB_LAST_ADDR_CACHE_EN.
module tb_rom_access_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int WC = 2;

  typedef struct {
    logic        id;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          ack0, ack1, busy, rom__CS, rom__OE;
  logic [DW-1:0] rdata;
  logic [AW-1:0] rom_A;
  wire  [DW-1:0] rom_D;

  logic [DW-1:0] rom_mem [16];
  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] prev_a = '0;
  logic          prev_oe = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i);

  // Asynchronous ROM: drives only while both enables are low.
  assign rom_D = (!rom__CS && !rom__OE) ? rom_mem[rom_A] : 'z;

  rom_access_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .rom_A(rom_A), .rom__CS(rom__CS), .rom__OE(rom__OE), .rom_D(rom_D)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard compare on every ack, plus pin invariants.
  always @(negedge clk) begin
    if (!reset) begin
      check("ack_exclusive", int'(ack0 && ack1), 0);
      check("cs_eq_oe", int'(rom__CS), int'(rom__OE));
      if (!prev_oe && !rom__OE) check("rom_A_stable", int'(rom_A), int'(prev_a));
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("ack%0d rdata=%0h cycle=%0d", ack1 ? 1 : 0, rdata, cyc);
          check("ack_id", int'(ack1), int'(e.id));
          check("ack_rdata", int'(rdata), int'(e.data));
          check("ack_cycle", cyc, e.cyc);
        end
      end
    end
    prev_a  <= rom_A;
    prev_oe <= rom__OE;
  end

  task automatic wait_ack(input logic id, output int en_cycles);
    bit got = 0;
    en_cycles = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!rom__CS) en_cycles++;
      if (id ? ack1 : ack0) got = 1;
    end
    check("ack_timeout", int'(got), 1);
  endtask

  // Single request: lat is the expected ack delay beyond the sampling edge.
  task automatic do_read(input logic id, input logic [AW-1:0] a,
                         input int lat, input int exp_en);
    int en;
    @(negedge clk);
    if (id) begin req1 = 1'b1; addr1 = a; end
    else    begin req0 = 1'b1; addr0 = a; end
    sb.push_back('{id, 8'(a), cyc + 1 + lat});
    wait_ack(id, en);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    check("rom_enable_cycles", en, exp_en);
  endtask

  initial begin
    int en;
    int hit_lat;
    int hit_en;
    // 1: reset held 3 cycles with req0 high.
    req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", int'(rom__CS), 1);
    check("rst_oe", int'(rom__OE), 1);
    check("rst_ack0", int'(ack0), 0);
    check("rst_ack1", int'(ack1), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    req0 = 1'b0;

    // 2: single read of address 2.
    do_read(1'b0, 4'd2, WC, WC);

    // 3: contention; last winner was requester 0, so requester 1 goes first.
    @(negedge clk);
    req0 = 1'b1; addr0 = 4'd3;
    req1 = 1'b1; addr1 = 4'd15;
    sb.push_back('{1'b1, 8'h0F, cyc + 1 + WC});
    sb.push_back('{1'b0, 8'h03, cyc + 1 + 2 * WC + 2});
    wait_ack(1'b1, en);
    req1 = 1'b0;
    wait_ack(1'b0, en);
    req0 = 1'b0;

    // 4: address changes mid-ACCESS; latched address must be used.
    @(negedge clk);
    req0 = 1'b1; addr0 = 4'd2;
    sb.push_back('{1'b0, 8'h02, cyc + 1 + WC});
    @(negedge clk);
    addr0 = 4'd5;
    check("busy_in_access", int'(busy), 1);
    @(negedge clk);
    check("rom_A_latched", int'(rom_A), 2);
    wait_ack(1'b0, en);
    req0 = 1'b0;

    // 5: reset during the first ACCESS cycle; no ack may follow.
    @(negedge clk);
    req0 = 1'b1; addr0 = 4'd9;
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("midrst_cs", int'(rom__CS), 1);
    check("midrst_oe", int'(rom__OE), 1);
    check("midrst_rdata", int'(rdata), 0);
    check("midrst_ack0", int'(ack0), 0);
    check("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 6: repeat read of 7 (cache hit when enabled), then 8, then requester 1.
`ifdef ROM_ARB_LAST_ADDR_CACHE_EN
    hit_lat = 0; hit_en = 0;
`else
    hit_lat = WC; hit_en = WC;
`endif
    do_read(1'b0, 4'd7, WC, WC);
    do_read(1'b0, 4'd7, hit_lat, hit_en);
    do_read(1'b0, 4'd8, WC, WC);
    do_read(1'b1, 4'd10, WC, WC);
    do_read(1'b1, 4'd0, WC, WC);

    repeat (6) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
